// File: rtl/wb_slave_ram_if.sv
// -----------------------------------------------------------------------------
// wb_slave_ram_if
// Wishbone B3 classic bus bundle that connects a CPU-side master to the
// wb_slave_ram responder. Signal names keep the slave-side _i/_o suffixes
// so that both ends refer to the same, familiar Wishbone names.
//
// Signals:
//   wb_adr_i [31:0]  byte address (master -> slave)
//   wb_dat_i [31:0]  write data   (master -> slave)
//   wb_dat_o [31:0]  read data    (slave -> master)
//   wb_we_i          1 = write, 0 = read
//   wb_sel_i [3:0]   byte lane enables
//   wb_stb_i         strobe
//   wb_cyc_i         cycle valid
//   wb_ack_o         single-cycle acknowledge
//   wb_err_o         error termination
// Modports: master (drives the request side), slave (drives the response side)
// -----------------------------------------------------------------------------
interface wb_slave_ram_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic        wb_we_i;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_err_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_err_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_we_i, wb_sel_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_err_o
  );
endinterface

// File: rtl/wb_slave_ram.sv
// -----------------------------------------------------------------------------
// wb_slave_ram
// Wishbone B3 classic slave in front of a synchronous single-port RAM of
// 2**ADDR_WIDTH 32-bit words. A programmable wait-state counter stretches
// every access so the CPU's bus-stall path gets exercised. Each transaction
// runs IDLE -> (WAIT) -> RESP -> TURN, giving one dead cycle between
// transactions so a late-dropping strobe is never acknowledged twice.
//
// Parameters:
//   ADDR_WIDTH   word-address bits (default 10 -> 4 KB)
//   WAIT_STATES  cycles between acceptance and ack, 0..15 (default 1)
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-low reset
//   bus   wb_slave_ram_if.slave (adr/dat/we/sel/stb/cyc in, dat/ack/err out)
//
// Optional feature (macro RAM_ERR_EN):
//   defined   - an access with address bits above the RAM range set ends
//               with wb_err_o instead of wb_ack_o and never writes the RAM
//   undefined - wb_err_o is constant 0 and such addresses alias into the RAM
// -----------------------------------------------------------------------------
module wb_slave_ram #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic          clk,
  input  logic          rst,
  wb_slave_ram_if.slave bus
);

  localparam int         DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
  localparam bit         NO_WAIT   = (WAIT_STATES == 0);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("wb_slave_ram: WAIT_STATES must be within 0..15");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_TURN} state_t;

  state_t                state;
  logic [3:0]            cnt;
  logic                  ready_q;
  logic [ADDR_WIDTH-1:0] idx_q;
  logic                  we_q;
  logic [3:0]            sel_q;
  logic [31:0]           dat_q;
  logic                  bad_q;
  logic                  ack_q;
  logic                  err_q;
  logic [31:0]           rdat_q;

  logic [31:0] mem [DEPTH];

  logic                  request;
  logic                  accept;
  logic                  go_resp;
  logic                  write_en;
  logic                  adr_bad;
  logic                  cur_we;
  logic                  cur_bad;
  logic [ADDR_WIDTH-1:0] cur_idx;
  logic [3:0]            cur_sel;
  logic [31:0]           cur_dat;
  logic                  unused_bits;

  assign request = bus.wb_cyc_i & bus.wb_stb_i;

  // ready_q keeps a request that is present while reset is held from being
  // taken (and, with no wait states, written) on the very edge reset lifts.
  assign accept = (state == S_IDLE) & request & ready_q;

  `ifdef RAM_ERR_EN
  assign adr_bad     = |bus.wb_adr_i[31:ADDR_WIDTH+2];
  assign unused_bits = ^bus.wb_adr_i[1:0];
  `else
  assign adr_bad     = 1'b0;
  assign unused_bits = ^{bus.wb_adr_i[1:0], bus.wb_adr_i[31:ADDR_WIDTH+2]};
  `endif

  // With no wait states the response edge is also the acceptance edge, so the
  // request fields come straight from the bus; otherwise the latched copies
  // are used and later bus changes have no effect.
  assign cur_idx = accept ? bus.wb_adr_i[ADDR_WIDTH+1:2] : idx_q;
  assign cur_we  = accept ? bus.wb_we_i                  : we_q;
  assign cur_sel = accept ? bus.wb_sel_i                 : sel_q;
  assign cur_dat = accept ? bus.wb_dat_i                 : dat_q;
  assign cur_bad = accept ? adr_bad                      : bad_q;

  assign go_resp  = (accept & NO_WAIT)
                  | ((state == S_WAIT) & request & (cnt == 4'd1));
  assign write_en = go_resp & cur_we & ~cur_bad;

  // RAM array: byte-lane write on the edge that enters RESP; never reset.
  always_ff @(posedge clk) begin
    if (write_en) begin
      for (int b = 0; b < 4; b++) begin
        if (cur_sel[b]) begin
          mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
        end
      end
    end
  end

  // Transaction FSM with registered ack/err/read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      ready_q <= 1'b0;
      idx_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= 4'd0;
      dat_q   <= 32'd0;
      bad_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdat_q  <= 32'd0;
    end else begin
      ready_q <= 1'b1;
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx_q <= cur_idx;
            we_q  <= cur_we;
            sel_q <= cur_sel;
            dat_q <= cur_dat;
            bad_q <= cur_bad;
            cnt   <= WAIT_LOAD;
            state <= NO_WAIT ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          // A dropped request abandons the access before anything is written.
          if (!request) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
          end else if (cnt == 4'd1) begin
            state <= S_RESP;
            cnt   <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          rdat_q <= 32'd0;
          state  <= S_TURN;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase

      if (go_resp) begin
        if (cur_bad) begin
          err_q <= 1'b1;
        end else begin
          ack_q <= 1'b1;
          if (!cur_we) begin
            rdat_q <= mem[cur_idx];
          end
        end
      end
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_err_o = err_q;
  assign bus.wb_dat_o = rdat_q;

endmodule

// File: tb/tb_wb_slave_ram.sv
// -----------------------------------------------------------------------------
// tb_wb_slave_ram
// Directed self-checking bench for wb_slave_ram. Three instances with
// WAIT_STATES 0, 1 and 3 share one set of request signals; 'which' selects
// the instance that sees cyc/stb and whose outputs are observed.
// Compile with +define+RAM_ERR_EN to select the error-termination behaviour.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_wb_slave_ram;

  logic        clk = 1'b0;
  logic        rst;
  int          which;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic        we;
  logic [3:0]  sel;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        err;
  logic [31:0] dat_rd;

  int checks   = 0;
  int failures = 0;

  wb_slave_ram_if if0 ();
  wb_slave_ram_if if1 ();
  wb_slave_ram_if if3 ();

  assign if0.wb_adr_i = adr;
  assign if0.wb_dat_i = dat_w;
  assign if0.wb_we_i  = we;
  assign if0.wb_sel_i = sel;
  assign if0.wb_cyc_i = cyc && (which == 0);
  assign if0.wb_stb_i = stb && (which == 0);

  assign if1.wb_adr_i = adr;
  assign if1.wb_dat_i = dat_w;
  assign if1.wb_we_i  = we;
  assign if1.wb_sel_i = sel;
  assign if1.wb_cyc_i = cyc && (which == 1);
  assign if1.wb_stb_i = stb && (which == 1);

  assign if3.wb_adr_i = adr;
  assign if3.wb_dat_i = dat_w;
  assign if3.wb_we_i  = we;
  assign if3.wb_sel_i = sel;
  assign if3.wb_cyc_i = cyc && (which == 3);
  assign if3.wb_stb_i = stb && (which == 3);

  wb_slave_ram #(.ADDR_WIDTH(10), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  wb_slave_ram #(.ADDR_WIDTH(10), .WAIT_STATES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  wb_slave_ram #(.ADDR_WIDTH(10), .WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

  // Observe the selected instance.
  always_comb begin
    ack    = 1'b0;
    err    = 1'b0;
    dat_rd = 32'd0;
    case (which)
      0: begin ack = if0.wb_ack_o; err = if0.wb_err_o; dat_rd = if0.wb_dat_o; end
      1: begin ack = if1.wb_ack_o; err = if1.wb_err_o; dat_rd = if1.wb_dat_o; end
      default: begin ack = if3.wb_ack_o; err = if3.wb_err_o; dat_rd = if3.wb_dat_o; end
    endcase
  end

  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One full Wishbone transfer on instance 'dut'. Returns the number of edges
  // from acceptance to the first ack/err sample (0 = none within budget), the
  // terminating values, and the outputs seen in the following turnaround cycle.
  // With 'scramble' set, the request fields change right after acceptance.
  task automatic applyStimulus(input int dut, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s, input bit scramble,
                               output int lat, output logic got_ack, output logic got_err,
                               output logic [31:0] got_dat, output logic turn_term,
                               output logic [31:0] turn_dat);
    @(negedge clk);
    which = dut; adr = a; dat_w = d; we = w; sel = s; cyc = 1'b1; stb = 1'b1;
    lat = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = 32'd0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      if (scramble && i == 1) begin
        #1;
        adr = 32'h0000_0018; dat_w = ~d; sel = 4'h0; we = ~w;
      end
      @(negedge clk);
      if (ack || err) begin
        lat = i; got_ack = ack; got_err = err; got_dat = dat_rd;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); @(negedge clk);
    turn_term = ack | err;
    turn_dat  = dat_rd;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic writeWord(input int dut, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int exp_lat, input bit scramble, input string tag);
    int l; logic ak, er, tt; logic [31:0] gd, td;
    applyStimulus(dut, 1'b1, a, d, s, scramble, l, ak, er, gd, tt, td);
    checkOutput({tag, "_ack"}, 32'(ak), 32'd1);
    checkOutput({tag, "_err"}, 32'(er), 32'd0);
    checkOutput({tag, "_lat"}, 32'(l), 32'(exp_lat));
    checkOutput({tag, "_turn"}, 32'(tt), 32'd0);
  endtask

  task automatic readWord(input int dut, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] exp_dat, input int exp_lat, input string tag);
    int l; logic ak, er, tt; logic [31:0] gd, td;
    applyStimulus(dut, 1'b0, a, 32'h0, s, 1'b0, l, ak, er, gd, tt, td);
    checkOutput({tag, "_ack"}, 32'(ak), 32'd1);
    checkOutput({tag, "_lat"}, 32'(l), 32'(exp_lat));
    checkOutput({tag, "_dat"}, gd, exp_dat);
    checkOutput({tag, "_turn_dat"}, td, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          l;
    int          seen;
    logic        ak, er, tt;
    logic [31:0] gd, td;

    // Reset held with a live request: nothing may respond.
    rst = 1'b0; which = 0; adr = 32'h10; dat_w = 32'h0; we = 1'b0; sel = 4'hF;
    cyc = 1'b1; stb = 1'b1;
    for (int k = 0; k < 2; k++) begin
      which = k;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("rst_ack_%0d", k), 32'(ack), 32'd0);
      checkOutput($sformatf("rst_dat_%0d", k), dat_rd, 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen += int'(if0.wb_ack_o | if1.wb_ack_o | if3.wb_ack_o | if0.wb_err_o | if1.wb_err_o | if3.wb_err_o);
    end
    checkOutput("idle_no_ack", 32'(seen), 32'd0);

    // Write / readback with one wait state.
    writeWord(1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 2, 1'b0, "wr10");
    readWord(1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 2, "rd10");

    // Request fields changed after acceptance must be ignored.
    writeWord(1, 32'h0000_0018, 32'h0101_0101, 4'hF, 2, 1'b0, "wr18");
    writeWord(1, 32'h0000_0014, 32'hCAFE_F00D, 4'hF, 2, 1'b1, "wr14s");
    readWord(1, 32'h0000_0014, 4'hF, 32'hCAFE_F00D, 2, "rd14");
    readWord(1, 32'h0000_0018, 4'hF, 32'h0101_0101, 2, "rd18");

    // Byte lanes.
    writeWord(1, 32'h0000_0020, 32'h1122_3344, 4'hF, 2, 1'b0, "wr20");
    writeWord(1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101, 2, 1'b0, "wr20s5");
    readWord(1, 32'h0000_0020, 4'hF, 32'h11BB_33DD, 2, "rd20a");
    writeWord(1, 32'h0000_0020, 32'hFFFF_FFFF, 4'b0000, 2, 1'b0, "wr20s0");
    readWord(1, 32'h0000_0020, 4'b0000, 32'h11BB_33DD, 2, "rd20b");

    // Abort with three wait states: strobe drops one cycle after acceptance.
    writeWord(3, 32'h0000_0030, 32'h1234_5678, 4'hF, 4, 1'b0, "wr30");
    @(negedge clk);
    which = 3; adr = 32'h30; dat_w = 32'h5555_5555; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); @(negedge clk);
    stb = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen += int'(ack | err);
    end
    cyc = 1'b0;
    checkOutput("abort_no_ack", 32'(seen), 32'd0);
    readWord(3, 32'h0000_0030, 4'hF, 32'h1234_5678, 4, "rd30a");

    // Reset in the middle of a waiting write.
    @(negedge clk);
    which = 3; adr = 32'h30; dat_w = 32'h7777_7777; we = 1'b1; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst = 1'b0; cyc = 1'b0; stb = 1'b0;
    seen = int'(ack | err);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen += int'(ack | err);
    end
    checkOutput("rstmid_no_ack", 32'(seen), 32'd0);
    readWord(3, 32'h0000_0030, 4'hF, 32'h1234_5678, 4, "rd30b");

    // Zero wait states, then a strobe held high for a single read.
    writeWord(0, 32'h0000_0040, 32'hA5A5_0F0F, 4'hF, 1, 1'b0, "wr40");
    readWord(0, 32'h0000_0040, 4'hF, 32'hA5A5_0F0F, 1, "rd40");
    @(negedge clk);
    which = 0; adr = 32'h40; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); @(negedge clk);
      checkOutput($sformatf("stuck_ack_%0d", k), 32'(ack), (k % 3 == 1) ? 32'd1 : 32'd0);
      checkOutput($sformatf("stuck_dat_%0d", k), dat_rd, (k % 3 == 1) ? 32'hA5A5_0F0F : 32'd0);
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (2) @(negedge clk);

    // Address above the RAM range.
    writeWord(1, 32'h0000_0000, 32'h0BAD_F00D, 4'hF, 2, 1'b0, "wr00");
    applyStimulus(1, 1'b1, 32'h0000_1000, 32'hFEED_FACE, 4'hF, 1'b0, l, ak, er, gd, tt, td);
    checkOutput("oor_lat", 32'(l), 32'd2);
    checkOutput("oor_turn", 32'(tt), 32'd0);
    checkOutput("oor_dat", gd, 32'd0);
`ifdef RAM_ERR_EN
    checkOutput("oor_ack", 32'(ak), 32'd0);
    checkOutput("oor_err", 32'(er), 32'd1);
    readWord(1, 32'h0000_0000, 4'hF, 32'h0BAD_F00D, 2, "rd00");
`else
    checkOutput("oor_ack", 32'(ak), 32'd1);
    checkOutput("oor_err", 32'(er), 32'd0);
    readWord(1, 32'h0000_0000, 4'hF, 32'hFEED_FACE, 2, "rd00");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
